// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding/flush controller: forward selects,
// exception codes and FSM state types.
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [31:0] EXC_INT  = 32'h01;
  localparam logic [31:0] EXC_ADEL = 32'h04;
  localparam logic [31:0] EXC_ADES = 32'h05;
  localparam logic [31:0] EXC_SYS  = 32'h08;
  localparam logic [31:0] EXC_BP   = 32'h09;
  localparam logic [31:0] EXC_RI   = 32'h0a;
  localparam logic [31:0] EXC_OV   = 32'h0c;
  localparam logic [31:0] EXC_ERET = 32'h0e;

  typedef enum logic [1:0] {DIDLE, DBUSY, DDONE} divState_t;
  typedef enum logic       {XIDLE, XHOLD}        excState_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller bundle; master is the pipeline, slave the controller.
interface hazard_ctrl_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 32
);
   logic [REG_AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic              branchD, jrD, jalrD;
   logic              regwriteE, memtoregE, divE;
   logic              regwriteM, memtoregM, regwriteW;
   logic [31:0]       excepttypeM, epcM;
   logic              i_stall, d_stall, perf_clr;

   logic              stallF, stallD, stallE, stallM, stallW;
   logic              flushF, flushD, flushE, flushM, flushW;
   logic              forwardaD, forwardbD;
   logic [1:0]        forwardaE, forwardbE;
   logic              div_startE, pc_redirect, longest_stall;
   logic [31:0]       newPC;
   logic [CNT_W-1:0]  cnt_istall, cnt_dstall, cnt_hazard;

   modport master (
      output rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
             branchD, jrD, jalrD, regwriteE, memtoregE, divE,
             regwriteM, memtoregM, regwriteW, excepttypeM, epcM,
             i_stall, d_stall, perf_clr,
      input  stallF, stallD, stallE, stallM, stallW,
             flushF, flushD, flushE, flushM, flushW,
             forwardaD, forwardbD, forwardaE, forwardbE,
             div_startE, pc_redirect, longest_stall, newPC,
             cnt_istall, cnt_dstall, cnt_hazard
   );

   modport slave (
      input  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW,
             branchD, jrD, jalrD, regwriteE, memtoregE, divE,
             regwriteM, memtoregM, regwriteW, excepttypeM, epcM,
             i_stall, d_stall, perf_clr,
      output stallF, stallD, stallE, stallM, stallW,
             flushF, flushD, flushE, flushM, flushW,
             forwardaD, forwardbD, forwardaE, forwardbE,
             div_startE, pc_redirect, longest_stall, newPC,
             cnt_istall, cnt_dstall, cnt_hazard
   );
endinterface

// File: rtl/div_stall_tracker.sv
// Multi-cycle divide tracker: pulses the divider start and holds E until the
// result is due (start cycle + DIV_CYCLES-1 busy cycles).
module div_stall_tracker #(
   parameter int DIV_CYCLES = 32
) (
   input  logic clk,
   input  logic resetn,
   input  logic divE,
   input  logic startOk,
   input  logic stallE,
   input  logic flush,
   output logic divStartE,
   output logic divStall
);
   import hazard_pkg::*;

   localparam int CW = $clog2(DIV_CYCLES);

   divState_t     state, nextState;
   logic [CW-1:0] cnt, cntNext;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= DIDLE;
         cnt   <= '0;
      end else begin
         state <= nextState;
         cnt   <= cntNext;
      end
   end

   always_comb begin
      nextState = state;
      cntNext   = cnt;
      divStartE = 1'b0;
      case (state)
         DIDLE: if (divE && startOk) begin
            divStartE = 1'b1;
            cntNext   = CW'(DIV_CYCLES - 1);
            nextState = DBUSY;
         end
         DBUSY: begin
            cntNext = cnt - CW'(1);
            if (cnt <= CW'(1)) nextState = DDONE;
         end
         DDONE: if (!stallE) nextState = DIDLE;
         default: nextState = DIDLE;
      endcase
      // a redirect kills the div in E, so the tracker must not outlive it
      if (flush) begin
         nextState = DIDLE;
         cntNext   = '0;
      end
   end

   assign divStall = divE && (state != DDONE);

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage MIPS hazard/forwarding/flush controller with divide stall tracking,
// deferred exception redirect and saturating stall statistics.
module hazard_ctrl #(
   parameter int          REG_AW     = 5,
   parameter int          DIV_CYCLES = 32,
   parameter logic [31:0] EXC_VEC    = 32'hbfc00380,
   parameter int          CNT_W      = 32
) (
   input logic           clk,
   input logic           resetn,
   hazard_ctrl_if.slave  hz
);
   import hazard_pkg::*;

   logic lwstall, branchstall, jrstall, hazStall;
   logic memstall, divStall, longestStall, exc, redirect, killDiv, divStart;
   logic stallUp, stallDn;

   excState_t   xState, xNext;
   logic [31:0] codeQ, epcQ, codeSel, epcSel;

   function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] dstM, input logic wrM,
                                         input logic [REG_AW-1:0] dstW, input logic wrW);
      if (src == '0)             return FWD_RF;
      if (wrM && src == dstM)    return FWD_M;
      if (wrW && src == dstW)    return FWD_W;
      return FWD_RF;
   endfunction

   assign hz.forwardaD = (hz.rsD != '0) && (hz.rsD == hz.writeregM) && hz.regwriteM;
   assign hz.forwardbD = (hz.rtD != '0) && (hz.rtD == hz.writeregM) && hz.regwriteM;
   assign hz.forwardaE = fwdSel(hz.rsE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);
   assign hz.forwardbE = fwdSel(hz.rtE, hz.writeregM, hz.regwriteM, hz.writeregW, hz.regwriteW);

   assign lwstall     = hz.memtoregE && ((hz.rtE == hz.rsD) || (hz.rtE == hz.rtD));
   assign branchstall = hz.branchD &&
      ((hz.regwriteE && ((hz.writeregE == hz.rsD) || (hz.writeregE == hz.rtD))) ||
       (hz.memtoregM && ((hz.writeregM == hz.rsD) || (hz.writeregM == hz.rtD))));
   assign jrstall     = (hz.jrD || hz.jalrD) &&
      ((hz.regwriteE && (hz.writeregE == hz.rsD)) ||
       (hz.memtoregM && (hz.writeregM == hz.rsD)));
   assign hazStall    = lwstall || branchstall || jrstall;

   assign memstall     = hz.i_stall || hz.d_stall;
   assign longestStall = memstall || divStall;
   assign exc          = (hz.excepttypeM != '0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         xState <= XIDLE;
         codeQ  <= '0;
         epcQ   <= '0;
      end else begin
         xState <= xNext;
         if (xState == XIDLE && exc && memstall) begin
            codeQ <= hz.excepttypeM;
            epcQ  <= hz.epcM;
         end
      end
   end

   // XHOLD runs on the latched code/EPC; live inputs are ignored until it fires
   always_comb begin
      xNext    = xState;
      redirect = 1'b0;
      codeSel  = hz.excepttypeM;
      epcSel   = hz.epcM;
      case (xState)
         XIDLE: if (exc) begin
            if (memstall) xNext    = XHOLD;
            else          redirect = 1'b1;
         end
         XHOLD: begin
            codeSel = codeQ;
            epcSel  = epcQ;
            if (!memstall) begin
               redirect = 1'b1;
               xNext    = XIDLE;
            end
         end
         default: xNext = XIDLE;
      endcase
   end

   assign hz.pc_redirect = redirect;
   assign hz.newPC       = !redirect ? 32'h0 : (codeSel == EXC_ERET) ? epcSel : EXC_VEC;

   assign killDiv = exc || (xState == XHOLD);

   div_stall_tracker #(.DIV_CYCLES(DIV_CYCLES)) u_div (
      .clk       (clk),
      .resetn    (resetn),
      .divE      (hz.divE),
      .startOk   (!killDiv),
      .stallE    (stallDn),
      .flush     (redirect),
      .divStartE (divStart),
      .divStall  (divStall)
   );

   assign hz.div_startE    = divStart;
   assign hz.longest_stall = longestStall;

   assign stallUp   = !redirect && (longestStall || hazStall);
   assign stallDn   = !redirect && longestStall;
   assign hz.stallF = stallUp;
   assign hz.stallD = stallUp;
   assign hz.stallE = stallDn;
   assign hz.stallM = stallDn;
   assign hz.stallW = stallDn;

   assign hz.flushF = redirect;
   assign hz.flushD = redirect;
   assign hz.flushE = redirect || (hazStall && !longestStall);
   assign hz.flushM = redirect;
   assign hz.flushW = redirect;

   logic [2:0]       cntInc;
   logic [CNT_W-1:0] cnt [3];

   assign cntInc = {hazStall && !longestStall, hz.d_stall, hz.i_stall};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 3; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (hz.perf_clr)                  cnt[i] <= '0;
            else if (cntInc[i] && !(&cnt[i])) cnt[i] <= cnt[i] + CNT_W'(1);
         end
      end
   end

   assign hz.cnt_istall = cnt[0];
   assign hz.cnt_dstall = cnt[1];
   assign hz.cnt_hazard = cnt[2];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: table of combinational vectors plus hand-written
// divide, deferred-exception, counter-saturation and reset sequences.
module tb_hazard_ctrl;

   localparam logic [31:0] VEC = 32'hbfc00380;

   logic clk, resetn;
   hazard_ctrl_if #(.REG_AW(5), .CNT_W(4)) hz ();

   hazard_ctrl #(.REG_AW(5), .DIV_CYCLES(4), .EXC_VEC(VEC), .CNT_W(4)) dut (
      .clk(clk), .resetn(resetn), .hz(hz.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [4:0] rsD, rtD;
      logic       branchD, jrD, jalrD;
      logic [4:0] rsE, rtE, writeregE;
      logic       regwriteE, memtoregE;
      logic [4:0] writeregM, writeregW;
      logic       regwriteM, memtoregM, regwriteW;
      logic [31:0] exc, epc;
      logic       iSt, dSt;
   } in_t;

   typedef struct packed {
      logic [4:0]  st;    // F D E M W
      logic [4:0]  fl;    // F D E M W
      logic [1:0]  fd;    // a b
      logic [1:0]  fa, fb;
      logic        ds, rd, lg;
      logic [31:0] pc;
   } obs_t;

   typedef struct {
      string name;
      in_t   in;
      obs_t  o;
   } vec_t;

   typedef struct {
      string      name;
      obs_t       o;
      bit         cc;
      logic [3:0] ci, cd, ch;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[$];
   int   nCmp = 0, nBad = 0;

   localparam logic [4:0] ALL = 5'b11111, FD = 5'b11000, FE = 5'b00100, NO = 5'b00000;

   function automatic obs_t mk(logic [4:0] st, logic [4:0] fl, logic [1:0] fd,
                               logic [1:0] fa, logic [1:0] fb,
                               logic ds, logic rd, logic lg, logic [31:0] pc);
      obs_t r;
      r = {st, fl, fd, fa, fb, ds, rd, lg, pc};
      return r;
   endfunction

   function automatic obs_t sample();
      obs_t r;
      r = {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.stallW,
           hz.flushF, hz.flushD, hz.flushE, hz.flushM, hz.flushW,
           hz.forwardaD, hz.forwardbD, hz.forwardaE, hz.forwardbE,
           hz.div_startE, hz.pc_redirect, hz.longest_stall, hz.newPC};
      return r;
   endfunction

   task automatic drive(input in_t v);
      hz.rsD = v.rsD; hz.rtD = v.rtD;
      hz.branchD = v.branchD; hz.jrD = v.jrD; hz.jalrD = v.jalrD;
      hz.rsE = v.rsE; hz.rtE = v.rtE; hz.writeregE = v.writeregE;
      hz.regwriteE = v.regwriteE; hz.memtoregE = v.memtoregE;
      hz.writeregM = v.writeregM; hz.writeregW = v.writeregW;
      hz.regwriteM = v.regwriteM; hz.memtoregM = v.memtoregM; hz.regwriteW = v.regwriteW;
      hz.excepttypeM = v.exc; hz.epcM = v.epc;
      hz.i_stall = v.iSt; hz.d_stall = v.dSt;
   endtask

   // push expectation now, compare at negedge, leave at posedge+1
   task automatic run(input exp_t e);
      exp_t q;
      obs_t g;
      sb.push_back(e);
      @(negedge clk);
      q = sb.pop_front();
      g = sample();
      nCmp++;
      if (g !== q.o) begin
         nBad++;
         $display("FAIL %s: got st=%b fl=%b fd=%b fa=%b fb=%b start=%b redir=%b long=%b pc=%h, want st=%b fl=%b fd=%b fa=%b fb=%b start=%b redir=%b long=%b pc=%h",
                  q.name, g.st, g.fl, g.fd, g.fa, g.fb, g.ds, g.rd, g.lg, g.pc,
                  q.o.st, q.o.fl, q.o.fd, q.o.fa, q.o.fb, q.o.ds, q.o.rd, q.o.lg, q.o.pc);
      end
      if (q.cc) begin
         nCmp++;
         if (hz.cnt_istall !== q.ci || hz.cnt_dstall !== q.cd || hz.cnt_hazard !== q.ch) begin
            nBad++;
            $display("FAIL %s counters: got i=%0d d=%0d h=%0d, want i=%0d d=%0d h=%0d",
                     q.name, hz.cnt_istall, hz.cnt_dstall, hz.cnt_hazard, q.ci, q.cd, q.ch);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic chk(input string n, input obs_t o);
      exp_t e;
      e.name = n; e.o = o; e.cc = 1'b0; e.ci = 0; e.cd = 0; e.ch = 0;
      run(e);
   endtask

   task automatic chkCnt(input string n, input obs_t o, input logic [3:0] ci, cd, ch);
      exp_t e;
      e.name = n; e.o = o; e.cc = 1'b1; e.ci = ci; e.cd = cd; e.ch = ch;
      run(e);
   endtask

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic add(input string n, input in_t v, input obs_t o);
      vec_t t;
      t.name = n; t.in = v; t.o = o;
      tbl.push_back(t);
   endtask

   obs_t Z, SALL, SDIV;
   in_t  v;
   logic [31:0] codes [2];
   logic [31:0] epcs  [2];
   logic [31:0] pcs   [2];

   initial begin
      Z    = '0;
      SALL = mk(ALL, NO, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 32'h0);
      SDIV = mk(ALL, NO, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 32'h0);

      v = '0;                                            add("idle", v, Z);
      v = '0; v.rsE = 5; v.rtE = 5; v.regwriteM = 1; v.writeregM = 5;
      v.regwriteW = 1; v.writeregW = 5;                  add("fwdE_Mprio", v, mk(NO, NO, 2'b00, 2'b10, 2'b10, 0, 0, 0, 0));
      v.rsE = 0;                                         add("fwdE_rs0", v, mk(NO, NO, 2'b00, 2'b00, 2'b10, 0, 0, 0, 0));
      v = '0; v.rsE = 7; v.rtE = 7; v.regwriteW = 1; v.writeregW = 7;
      v.regwriteM = 1; v.writeregM = 6;                  add("fwdE_W", v, mk(NO, NO, 2'b00, 2'b01, 2'b01, 0, 0, 0, 0));
      v = '0; v.rsD = 9; v.rtD = 4; v.regwriteM = 1; v.writeregM = 9;
                                                         add("fwdD", v, mk(NO, NO, 2'b10, 2'b00, 2'b00, 0, 0, 0, 0));
      v = '0; v.memtoregE = 1; v.rtE = 3; v.rsD = 3;     add("lwstall", v, mk(FD, FE, 0, 0, 0, 0, 0, 0, 0));
      v.dSt = 1;                                         add("lwstall_dstall", v, SALL);
      v = '0; v.branchD = 1; v.rsD = 2; v.rtD = 8; v.regwriteE = 1; v.writeregE = 8;
                                                         add("branchstall", v, mk(FD, FE, 0, 0, 0, 0, 0, 0, 0));
      v = '0; v.jrD = 1; v.rsD = 6; v.memtoregM = 1; v.regwriteM = 1; v.writeregM = 6;
                                                         add("jrstall_M", v, mk(FD, FE, 2'b10, 0, 0, 0, 0, 0, 0));
      v = '0; v.jalrD = 1; v.rsD = 1; v.rtD = 6; v.regwriteE = 1; v.writeregE = 6;
                                                         add("jalr_rtOnly", v, Z);
      v = '0; v.iSt = 1;                                 add("istall", v, SALL);
      v = '0; v.exc = 32'h08; v.epc = 32'h123; v.memtoregE = 1; v.rtE = 3; v.rsD = 3;
                                                         add("excOverride", v, mk(NO, ALL, 0, 0, 0, 0, 1, 0, VEC));
      v = '0; v.exc = 32'h0e; v.epc = 32'h80000040;      add("eretNow", v, mk(NO, ALL, 0, 0, 0, 0, 1, 0, 32'h80000040));

      resetn = 1'b0;
      hz.divE = 1'b0; hz.perf_clr = 1'b0;
      drive('0);
      #2;
      chkCnt("reset", Z, 0, 0, 0);
      resetn = 1'b1;
      chk("postReset", Z);

      foreach (tbl[i]) begin
         drive(tbl[i].in);
         chk(tbl[i].name, tbl[i].o);
      end
      drive('0);
      chkCnt("cntTable", Z, 1, 1, 4);
      hz.perf_clr = 1'b1; chk("clr", Z);
      hz.perf_clr = 1'b0; chkCnt("cntClr", Z, 0, 0, 0);

      // divide with DIV_CYCLES=4: four stalled cycles then release
      hz.divE = 1'b1;
      chk("divStart", SDIV);
      for (int i = 0; i < 3; i++) chk("divBusy", SALL);
      chk("divDone", Z);
      hz.divE = 1'b0;
      chk("divIdle", Z);

      // exception beats a same-cycle divide
      hz.divE = 1'b1; hz.excepttypeM = 32'h01;
      chk("divExc", mk(NO, ALL, 0, 0, 0, 0, 1, 1, VEC));
      hz.excepttypeM = '0;
      chk("divAfterExc", SDIV);
      cycles(4);
      hz.divE = 1'b0;
      cycles(1);

      codes[0] = 32'h01; epcs[0] = 32'h00400010; pcs[0] = VEC;
      codes[1] = 32'h0e; epcs[1] = 32'h80001234; pcs[1] = 32'h80001234;
      for (int k = 0; k < 2; k++) begin
         hz.excepttypeM = codes[k]; hz.epcM = epcs[k]; hz.d_stall = 1'b1;
         chk("excHold0", SALL);
         hz.excepttypeM = '0; hz.epcM = 32'hdeadbeef;
         for (int i = 0; i < 5; i++) chk("excHold", SALL);
         hz.d_stall = 1'b0;
         chk("excDeferred", mk(NO, ALL, 0, 0, 0, 0, 1, 0, pcs[k]));
         chk("excAfter", Z);
      end

      hz.perf_clr = 1'b1; chk("clr2", Z);
      hz.perf_clr = 1'b0; hz.i_stall = 1'b1;
      cycles(19);
      chkCnt("cntSat", SALL, 15, 0, 0);
      hz.perf_clr = 1'b1; chk("clrPrio", SALL);
      hz.perf_clr = 1'b0; hz.i_stall = 1'b0;
      chkCnt("cntCleared", Z, 0, 0, 0);

      // reset in DBUSY: fresh start must be possible right after release
      hz.divE = 1'b1;
      chk("rstDivStart", SDIV);
      cycles(1);
      resetn = 1'b0; hz.divE = 1'b0;
      chkCnt("rstDiv", Z, 0, 0, 0);
      resetn = 1'b1;
      chk("rstDivRel", Z);
      hz.divE = 1'b1;
      chk("rstDivRestart", SDIV);
      cycles(4);
      hz.divE = 1'b0;
      cycles(1);

      // reset in XHOLD: dropping d_stall afterwards must not redirect
      hz.excepttypeM = 32'h0c; hz.d_stall = 1'b1;
      chk("rstHold0", SALL);
      hz.excepttypeM = '0;
      cycles(1);
      resetn = 1'b0; hz.d_stall = 1'b0;
      chkCnt("rstHold", Z, 0, 0, 0);
      resetn = 1'b1;
      chk("rstHoldRel", Z);
      chk("rstHoldRel2", Z);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
